// File: rtl/tdm_demux_if.sv
// Bus bundle for the TDM demultiplexer: serial word input side plus the published
// parallel frame, alignment status and error outputs.
interface tdm_demux_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
);
    localparam int CW = $clog2(NUM_CH);

    logic                    din_valid;
    logic [WIDTH-1:0]        din;
    logic                    frame_sync;
    logic [NUM_CH*WIDTH-1:0] ch_data;
    logic                    frame_valid;
    logic                    locked;
    logic [CW-1:0]           slot;
    logic                    sync_err;

    modport master (
        output din_valid, din, frame_sync,
        input  ch_data, frame_valid, locked, slot, sync_err
    );

    modport slave (
        input  din_valid, din, frame_sync,
        output ch_data, frame_valid, locked, slot, sync_err
    );
endinterface

// File: rtl/tdm_demux.sv
// Receive side of a sample-interleaved TDM link: hunts for slot-0 alignment, stages
// each valid word by slot and publishes a full frame atomically on ch_data.
module tdm_demux #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    tdm_demux_if.slave  bus
);
    localparam int          CW   = $clog2(NUM_CH);
    localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);

    typedef enum logic {HUNT, RUN} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           slot_q, slot_d;
    logic [WIDTH-1:0]        stage_q [NUM_CH];
    logic [WIDTH-1:0]        stage_d [NUM_CH];
    logic [NUM_CH*WIDTH-1:0] ch_data_q, ch_data_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    sync_err_q, sync_err_d;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        stage_d       = stage_q;
        ch_data_d     = ch_data_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (bus.din_valid) begin
            case (state_q)
                HUNT: begin
                    if (bus.frame_sync) begin
                        stage_d[0] = bus.din;
                        slot_d     = CW'(1);
                        state_d    = RUN;
                    end
                end
                default: begin
                    if (slot_q == '0) begin
                        if (bus.frame_sync) begin
                            stage_d[0] = bus.din;
                            slot_d     = CW'(1);
                        end else begin
                            sync_err_d = 1'b1;
                            state_d    = HUNT;
                            slot_d     = '0;
                        end
                    end else if (bus.frame_sync) begin
                        // Early sync restarts the frame on this word; the partial frame is dropped.
                        sync_err_d = 1'b1;
                        stage_d[0] = bus.din;
                        slot_d     = CW'(1);
                    end else if (slot_q == LAST) begin
                        stage_d[slot_q] = bus.din;
                        for (int k = 0; k < NUM_CH - 1; k++) begin
                            ch_data_d[k*WIDTH +: WIDTH] = stage_q[k];
                        end
                        ch_data_d[(NUM_CH-1)*WIDTH +: WIDTH] = bus.din;
                        frame_valid_d = 1'b1;
                        slot_d        = '0;
                    end else begin
                        stage_d[slot_q] = bus.din;
                        slot_d          = slot_q + CW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            slot_q        <= '0;
            ch_data_q     <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            ch_data_q     <= ch_data_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            stage_q       <= stage_d;
        end
    end

    assign bus.ch_data     = ch_data_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.locked      = (state_q == RUN);
    assign bus.slot        = slot_q;
    assign bus.sync_err    = sync_err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (NUM_CH=4, WIDTH=8): alignment hunt, stalls, sync
// errors, back-to-back publishing and mid-frame reset.
module tb_tdm_demux;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   fv_cyc;

    tdm_demux_if #(.NUM_CH(4), .WIDTH(8)) bus ();

    tdm_demux #(.NUM_CH(4), .WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge, then settle just after the rising edge.
    task automatic step(input logic r, input logic v, input logic [7:0] d, input logic s);
        @(negedge clk);
        rst_n          = r;
        bus.din_valid  = v;
        bus.din        = d;
        bus.frame_sync = s;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic st(input string tag, input logic lk, input logic [1:0] sl,
                      input logic fv, input logic se);
        chk({tag, ".locked"}, 64'(bus.locked), 64'(lk));
        chk({tag, ".slot"}, 64'(bus.slot), 64'(sl));
        chk({tag, ".frame_valid"}, 64'(bus.frame_valid), 64'(fv));
        chk({tag, ".sync_err"}, 64'(bus.sync_err), 64'(se));
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; fv_cyc = 0;
        rst_n = 1'b0;
        bus.din_valid = 1'b0; bus.din = '0; bus.frame_sync = 1'b0;

        // Reset then lock
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        st("rst", 0, 0, 0, 0);
        chk("rst.ch_data", 64'(bus.ch_data), 64'h0);
        step(1, 1, 8'h11, 1); st("t1.w0", 1, 1, 0, 0);
        step(1, 1, 8'h22, 0); st("t1.w1", 1, 2, 0, 0);
        step(1, 1, 8'h33, 0); st("t1.w2", 1, 3, 0, 0);
        chk("t1.ch_data_pre", 64'(bus.ch_data), 64'h0);
        step(1, 1, 8'h44, 0); st("t1.w3", 1, 0, 1, 0);
        chk("t1.ch_data", 64'(bus.ch_data), 64'h44332211);
        step(1, 0, 8'h00, 0); st("t1.idle", 1, 0, 0, 0);
        chk("t1.ch_hold", 64'(bus.ch_data), 64'h44332211);

        // Hunt discard and stalls
        step(0, 0, 8'h00, 0);
        chk("t2.rst_ch", 64'(bus.ch_data), 64'h0);
        step(1, 1, 8'hAA, 0); st("t2.aa", 0, 0, 0, 0);
        step(1, 1, 8'hBB, 0); st("t2.bb", 0, 0, 0, 0);
        step(1, 1, 8'h01, 1); st("t2.w0", 1, 1, 0, 0);
        step(1, 1, 8'h02, 0); st("t2.w1", 1, 2, 0, 0);
        step(1, 0, 8'hEE, 1); st("t2.stall", 1, 2, 0, 0);
        step(1, 1, 8'h03, 0); st("t2.w2", 1, 3, 0, 0);
        step(1, 1, 8'h04, 0); st("t2.w3", 1, 0, 1, 0);
        chk("t2.ch_data", 64'(bus.ch_data), 64'h04030201);
        step(1, 0, 8'h00, 0); st("t2.after", 1, 0, 0, 0);

        // Early sync
        step(1, 1, 8'h10, 1); st("t3.w10", 1, 1, 0, 0);
        step(1, 1, 8'h20, 0); st("t3.w20", 1, 2, 0, 0);
        step(1, 1, 8'h30, 1); st("t3.w30", 1, 1, 0, 1);
        step(1, 1, 8'h40, 0); st("t3.w40", 1, 2, 0, 0);
        step(1, 1, 8'h50, 0); st("t3.w50", 1, 3, 0, 0);
        chk("t3.no_pub", 64'(bus.ch_data), 64'h04030201);
        step(1, 1, 8'h60, 0); st("t3.w60", 1, 0, 1, 0);
        chk("t3.ch_data", 64'(bus.ch_data), 64'h60504030);

        // Missing sync at slot 0
        step(1, 1, 8'h77, 0); st("t4.w77", 0, 0, 0, 1);
        chk("t4.ch_hold", 64'(bus.ch_data), 64'h60504030);
        step(1, 1, 8'h81, 1); st("t4.w0", 1, 1, 0, 0);
        step(1, 1, 8'h82, 0);
        step(1, 1, 8'h83, 0);
        step(1, 1, 8'h84, 0); st("t4.w3", 1, 0, 1, 0);
        chk("t4.ch_data", 64'(bus.ch_data), 64'h84838281);

        // Back-to-back frames
        step(1, 1, 8'hA1, 1);
        step(1, 1, 8'hA2, 0);
        step(1, 1, 8'hA3, 0);
        step(1, 1, 8'hA4, 0); st("t5.a4", 1, 0, 1, 0);
        fv_cyc = cyc;
        chk("t5.ch_a", 64'(bus.ch_data), 64'hA4A3A2A1);
        step(1, 1, 8'hB1, 1); st("t5.b1", 1, 1, 0, 0);
        step(1, 1, 8'hB2, 0); st("t5.b2", 1, 2, 0, 0);
        step(1, 1, 8'hB3, 0); st("t5.b3", 1, 3, 0, 0);
        chk("t5.ch_hold", 64'(bus.ch_data), 64'hA4A3A2A1);
        step(1, 1, 8'hB4, 0); st("t5.b4", 1, 0, 1, 0);
        chk("t5.spacing", 64'(bus.frame_valid ? cyc - fv_cyc : 0), 64'd4);
        chk("t5.ch_b", 64'(bus.ch_data), 64'hB4B3B2B1);

        // Reset mid-frame
        step(1, 1, 8'hC1, 1);
        step(1, 1, 8'hC2, 0);
        step(1, 1, 8'hC3, 0); st("t6.c3", 1, 3, 0, 0);
        step(0, 1, 8'hC4, 0); st("t6.rst", 0, 0, 0, 0);
        chk("t6.ch_data", 64'(bus.ch_data), 64'h0);
        step(1, 1, 8'hD1, 1); st("t6.d1", 1, 1, 0, 0);
        step(1, 1, 8'hD2, 0);
        step(1, 1, 8'hD3, 0);
        step(1, 1, 8'hD4, 0); st("t6.d4", 1, 0, 1, 0);
        chk("t6.ch_relock", 64'(bus.ch_data), 64'hD4D3D2D1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
